// File: rtl/uart_tx_arbiter_if.sv
// Request/grant bundle between byte sources, the uart_tx arbiter and the uart_tx serializer.
// master: the side that drives requests and tx_done; slave: the arbiter itself.
interface uart_tx_arbiter_if #(
  parameter int NUM_REQ = 4
);
  localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0]   req_valid;
  logic [NUM_REQ*8-1:0] req_data;
  logic [NUM_REQ-1:0]   req_last;
  logic [NUM_REQ-1:0]   req_ready;
  logic                 tx_start;
  logic [7:0]           tx_data;
  logic                 tx_done;
  logic                 grant_valid;
  logic [ID_W-1:0]      grant_id;
  logic                 frame_abort;

  modport master (
    output req_valid, req_data, req_last, tx_done,
    input  req_ready, tx_start, tx_data, grant_valid, grant_id, frame_abort
  );

  modport slave (
    input  req_valid, req_data, req_last, tx_done,
    output req_ready, tx_start, tx_data, grant_valid, grant_id, frame_abort
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uart_tx among NUM_REQ byte sources; the owner keeps the
// transmitter until its last byte, or until it idles HOLD_TIMEOUT cycles between bytes.
module uart_tx_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int HOLD_TIMEOUT = 1024
) (
  input logic clk,
  input logic rst,
  uart_tx_arbiter_if.slave bus
);
  localparam int ID_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = (HOLD_TIMEOUT > 1) ? $clog2(HOLD_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(HOLD_TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, HOLD} state_e;

  state_e             state_q, state_d;
  logic [ID_W-1:0]    rr_q, rr_d;
  logic [ID_W-1:0]    gid_q, gid_d;
  logic               gvld_q, gvld_d;
  logic               last_q, last_d;
  logic               abort_q, abort_d;
  logic [7:0]         data_q, data_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [ID_W-1:0]    win_id, acc_id;
  logic [NUM_REQ-1:0] ready;
  logic               start;

  function automatic logic [ID_W-1:0] wrap_inc(input logic [ID_W-1:0] id);
    return ID_W'((int'(id) + 1) % NUM_REQ);
  endfunction

  function automatic logic [NUM_REQ-1:0] onehot(input logic [ID_W-1:0] id);
    return NUM_REQ'(1) << id;
  endfunction

  // Scan downward so the requester closest above ptr (with wrap) is assigned last and wins.
  function automatic logic [ID_W-1:0] rr_pick(input logic [NUM_REQ-1:0] v,
                                              input logic [ID_W-1:0]    ptr);
    logic [ID_W-1:0] id;
    id = ptr;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      int idx;
      idx = (int'(ptr) + k) % NUM_REQ;
      if (((v >> idx) & NUM_REQ'(1)) != '0) id = ID_W'(idx);
    end
    return id;
  endfunction

  assign win_id = rr_pick(bus.req_valid, rr_q);

  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    gid_d   = gid_q;
    gvld_d  = gvld_q;
    last_d  = last_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    abort_d = 1'b0;
    ready   = '0;
    start   = 1'b0;
    acc_id  = gid_q;
    case (state_q)
      IDLE: begin
        if (|bus.req_valid) begin
          acc_id = win_id;
          ready  = onehot(win_id);
        end
      end
      ISSUE: begin
        start   = 1'b1;
        state_d = WAIT;
      end
      WAIT: begin
        if (bus.tx_done) begin
          if (last_q) begin
            gvld_d  = 1'b0;
            gid_d   = '0;
            rr_d    = wrap_inc(gid_q);
            state_d = IDLE;
          end else begin
            cnt_d   = '0;
            state_d = HOLD;
          end
        end
      end
      HOLD: begin
        if ((bus.req_valid & onehot(gid_q)) != '0) begin
          ready = onehot(gid_q);
        end else if (cnt_q == CNT_MAX) begin
          abort_d = 1'b1;
          gvld_d  = 1'b0;
          gid_d   = '0;
          rr_d    = wrap_inc(gid_q);
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    // Any asserted ready is an acceptance, since ready is only raised on a valid requester.
    if (|ready) begin
      data_d  = 8'(bus.req_data >> (8 * int'(acc_id)));
      last_d  = |(bus.req_last & ready);
      gvld_d  = 1'b1;
      gid_d   = acc_id;
      state_d = ISSUE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      rr_q    <= '0;
      gid_q   <= '0;
      gvld_q  <= 1'b0;
      last_q  <= 1'b0;
      abort_q <= 1'b0;
      data_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      gid_q   <= gid_d;
      gvld_q  <= gvld_d;
      last_q  <= last_d;
      abort_q <= abort_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.req_ready   = ready;
  assign bus.tx_start    = start;
  assign bus.tx_data     = data_q;
  assign bus.grant_valid = gvld_q;
  assign bus.grant_id    = gid_q;
  assign bus.frame_abort = abort_q;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: directed vector table, multi-cycle corner sequences, and a
// randomized run against a transaction-level round-robin/frame-lock model.
module tb_uart_tx_arbiter;
  localparam int NR = 4;
  localparam int HT = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   done_cyc = 0;

  uart_tx_arbiter_if #(.NUM_REQ(NR)) bus();

  uart_tx_arbiter #(.NUM_REQ(NR), .HOLD_TIMEOUT(HT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [3:0]  v;
    logic [31:0] d;
    logic [3:0]  exp_r;
    logic [7:0]  exp_d;
    logic [1:0]  exp_id;
  } vec_t;

  vec_t tbl[7];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic obs();
    @(negedge clk);
  endtask

  task automatic set_idle();
    bus.req_valid = '0;
    bus.req_data  = '0;
    bus.req_last  = '0;
    bus.tx_done   = 1'b0;
  endtask

  task automatic do_reset();
    nxt();
    rst = 1'b1;
    set_idle();
    nxt();
    nxt();
    rst = 1'b0;
  endtask

  task automatic wait_start(input string nm);
    int n;
    n = 0;
    obs();
    while (!bus.tx_start && n < 40) begin
      nxt();
      obs();
      n++;
    end
    chk({nm, "_start"}, 32'(bus.tx_start), 32'd1);
  endtask

  task automatic done_pulse();
    nxt();
    bus.tx_done = 1'b1;
    obs();
    done_cyc = cyc;
    nxt();
    bus.tx_done = 1'b0;
  endtask

  function automatic logic [3:0] model_pick(input logic [3:0] v, input int rr);
    for (int j = 0; j < NR; j++) begin
      int idx;
      idx = (rr + j) % NR;
      if (((v >> idx) & 4'b1) != 4'b0) return 4'b1 << idx;
    end
    return 4'b0;
  endfunction

  initial begin
    logic [3:0]  nv, nl, v, r, er, acc, mi;
    logic [31:0] nd;
    logic [7:0]  m_byte;
    bit          ndone, m_locked, m_inflight, m_exp, m_last;
    int          gap[NR];
    int          left[NR];
    int          cd, m_rr, m_owner, sent, n;

    tbl[0] = '{4'b0001, 32'h0000_0055, 4'b0001, 8'h55, 2'd0};
    tbl[1] = '{4'b0101, 32'h1312_1110, 4'b0100, 8'h12, 2'd2};
    tbl[2] = '{4'b0101, 32'h1312_1110, 4'b0001, 8'h10, 2'd0};
    tbl[3] = '{4'b0101, 32'h1312_1110, 4'b0100, 8'h12, 2'd2};
    tbl[4] = '{4'b1111, 32'h1312_1110, 4'b1000, 8'h13, 2'd3};
    tbl[5] = '{4'b1110, 32'h1312_1110, 4'b0010, 8'h11, 2'd1};
    tbl[6] = '{4'b0011, 32'h1312_1110, 4'b0001, 8'h10, 2'd0};

    set_idle();
    do_reset();
    obs();
    chk("rst_ready", 32'(bus.req_ready), 32'd0);
    chk("rst_start", 32'(bus.tx_start), 32'd0);
    chk("rst_data", 32'(bus.tx_data), 32'd0);
    chk("rst_gvalid", 32'(bus.grant_valid), 32'd0);
    chk("rst_gid", 32'(bus.grant_id), 32'd0);
    chk("rst_abort", 32'(bus.frame_abort), 32'd0);
    nxt();

    // Single-byte frames; each row relies on the pointer left by the previous one.
    for (int i = 0; i < 7; i++) begin
      bus.req_valid = tbl[i].v;
      bus.req_data  = tbl[i].d;
      bus.req_last  = 4'b1111;
      obs();
      chk("vec_ready", 32'(bus.req_ready), 32'(tbl[i].exp_r));
      chk("vec_idle_gvalid", 32'(bus.grant_valid), 32'd0);
      nxt();
      bus.req_valid = '0;
      obs();
      chk("vec_start", 32'(bus.tx_start), 32'd1);
      chk("vec_data", 32'(bus.tx_data), 32'(tbl[i].exp_d));
      chk("vec_grant", 32'({bus.grant_valid, bus.grant_id}), 32'({1'b1, tbl[i].exp_id}));
      nxt();
      bus.req_valid = tbl[i].v;
      obs();
      chk("vec_wait_ready", 32'(bus.req_ready), 32'd0);
      chk("vec_wait_start", 32'(bus.tx_start), 32'd0);
      nxt();
      bus.req_valid = '0;
      bus.tx_done   = 1'b1;
      obs();
      nxt();
      bus.tx_done = 1'b0;
      obs();
      chk("vec_release", 32'({bus.grant_valid, bus.grant_id}), 32'd0);
      chk("vec_hold_data", 32'(bus.tx_data), 32'(tbl[i].exp_d));
      nxt();
    end

    // Round-robin with all four always valid.
    do_reset();
    bus.req_valid = 4'b1111;
    bus.req_data  = 32'h1312_1110;
    bus.req_last  = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      wait_start("rr");
      chk("rr_data", 32'(bus.tx_data), 32'(8'h10 + k % 4));
      if (k > 0) chk("rr_gap", 32'(cyc - done_cyc), 32'd2);
      done_pulse();
    end

    // Frame lock: req0 sends A0,A1,A2 while req1 waits with B0.
    do_reset();
    bus.req_valid = 4'b0011;
    bus.req_data  = {16'h0, 8'hB0, 8'hA0};
    bus.req_last  = 4'b0010;
    for (int k = 0; k < 4; k++) begin
      wait_start("lock");
      chk("lock_data", 32'(bus.tx_data), (k < 3) ? 32'(8'hA0 + k) : 32'hB0);
      if (k == 3) break;
      chk("lock_gid", 32'(bus.grant_id), 32'd0);
      nxt();
      if (k < 2) begin
        bus.req_data[7:0] = 8'(8'hA0 + k + 1);
        bus.req_last[0]   = (k == 1);
      end else begin
        bus.req_valid[0] = 1'b0;
      end
      obs();
      chk("lock_wait_ready", 32'(bus.req_ready), 32'd0);
      done_pulse();
      obs();
      chk("lock_next_ready", 32'(bus.req_ready), (k < 2) ? 32'b0001 : 32'b0010);
      nxt();
      if (k == 2) bus.req_valid = '0;
    end

    // Hold timeout: req0 sends C0 without last, then goes quiet; req2 waits with D2.
    do_reset();
    bus.req_valid = 4'b0101;
    bus.req_data  = {8'h0, 8'hD2, 8'h0, 8'hC0};
    bus.req_last  = 4'b0100;
    obs();
    chk("to_first_ready", 32'(bus.req_ready), 32'b0001);
    nxt();
    bus.req_valid = 4'b0100;
    wait_start("to");
    chk("to_data", 32'(bus.tx_data), 32'hC0);
    done_pulse();
    n = 0;
    obs();
    while (!bus.frame_abort && n < 40) begin
      chk("to_hold_ready", 32'(bus.req_ready), 32'd0);
      nxt();
      obs();
      n++;
    end
    chk("to_abort", 32'(bus.frame_abort), 32'd1);
    chk("to_abort_time", 32'(cyc - done_cyc), 32'd17);
    chk("to_gvalid", 32'(bus.grant_valid), 32'd0);
    chk("to_next_ready", 32'(bus.req_ready), 32'b0100);
    nxt();
    bus.req_valid = '0;
    wait_start("to_d2");
    chk("to_abort_pulse", 32'(bus.frame_abort), 32'd0);
    chk("to_d2_data", 32'(bus.tx_data), 32'hD2);
    chk("to_d2_gid", 32'(bus.grant_id), 32'd2);

    // Reset while a byte is in WAIT, then a clean grant to req1.
    do_reset();
    bus.req_valid = 4'b0001;
    bus.req_data  = 32'h11;
    bus.req_last  = 4'b0001;
    obs();
    nxt();
    bus.req_valid = '0;
    obs();
    nxt();
    obs();
    nxt();
    rst = 1'b1;
    obs();
    nxt();
    rst = 1'b0;
    bus.tx_done = 1'b1;
    obs();
    chk("mrst_outputs", 32'({bus.tx_start, bus.grant_valid, bus.grant_id, bus.frame_abort}), 32'd0);
    chk("mrst_data", 32'(bus.tx_data), 32'd0);
    chk("mrst_ready", 32'(bus.req_ready), 32'd0);
    nxt();
    bus.tx_done   = 1'b0;
    bus.req_valid = 4'b0010;
    bus.req_data  = {16'h0, 8'h77, 8'h0};
    bus.req_last  = 4'b0010;
    obs();
    chk("mrst_ready1", 32'(bus.req_ready), 32'b0010);
    nxt();
    bus.req_valid = '0;
    obs();
    chk("mrst_start", 32'(bus.tx_start), 32'd1);
    chk("mrst_tx_data", 32'(bus.tx_data), 32'h77);
    chk("mrst_gid", 32'({bus.grant_valid, bus.grant_id}), 32'({1'b1, 2'd1}));

    // Randomized traffic against the frame-level model.
    do_reset();
    nv = '0; nl = '0; nd = '0; ndone = 1'b0;
    cd = 0; m_rr = 0; m_owner = 0; sent = 0; m_byte = '0;
    m_locked = 1'b0; m_inflight = 1'b0; m_exp = 1'b0; m_last = 1'b0;
    for (int i = 0; i < NR; i++) begin
      left[i] = $urandom_range(1, 3);
      gap[i]  = $urandom_range(0, 4);
    end
    for (int c = 0; c < 3000; c++) begin
      if (c > 0) nxt();
      bus.req_valid = nv;
      bus.req_data  = nd;
      bus.req_last  = nl;
      bus.tx_done   = ndone;
      obs();
      v = bus.req_valid;
      r = bus.req_ready;
      chk("rnd_start", {23'd0, bus.tx_start, bus.tx_data & {8{bus.tx_start}}},
          {23'd0, m_exp, m_byte & {8{m_exp}}});
      chk("rnd_grant", 32'({bus.grant_valid, bus.grant_id}), m_locked ? 32'(4 + m_owner) : 32'd0);
      if (m_inflight)    er = 4'b0;
      else if (m_locked) er = v & (4'b1 << m_owner);
      else               er = model_pick(v, m_rr);
      chk("rnd_ready", 32'(r), 32'(er));
      m_exp = 1'b0;
      if (er != 4'b0) begin
        for (int i = 0; i < NR; i++) if (er == (4'b1 << i)) m_owner = i;
        m_locked   = 1'b1;
        m_inflight = 1'b1;
        m_byte     = 8'(bus.req_data >> (8 * m_owner));
        m_last     = ((bus.req_last & er) != 4'b0);
        m_exp      = 1'b1;
        sent++;
      end
      if (bus.tx_done && m_inflight) begin
        m_inflight = 1'b0;
        if (m_last) begin
          m_locked = 1'b0;
          m_rr     = (m_owner + 1) % NR;
        end
      end
      if (bus.tx_start) cd = $urandom_range(1, 6);
      ndone = (cd == 1);
      if (cd > 0) cd--;
      acc = v & r;
      for (int i = 0; i < NR; i++) begin
        mi = 4'b1 << i;
        if ((v & mi) != 4'b0 && (acc & mi) == 4'b0) continue;
        if ((acc & mi) != 4'b0) begin
          left[i]--;
          if (left[i] == 0) begin
            left[i] = $urandom_range(1, 3);
            gap[i]  = $urandom_range(0, 8);
          end else begin
            gap[i] = $urandom_range(0, 3);
          end
        end
        if (gap[i] == 0) begin
          nv = nv | mi;
          nd = (nd & ~(32'hFF << (8 * i))) | (32'($urandom_range(0, 255)) << (8 * i));
          nl = (left[i] == 1) ? (nl | mi) : (nl & ~mi);
        end else begin
          gap[i]--;
          nv = nv & ~mi;
        end
      end
    end
    chk("rnd_traffic", 32'(sent > 100), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
